// File: rtl/signal_debouncer.sv
//==============================================================================
// Module   : signal_debouncer
// Purpose  : Qualifies a raw level with a stability counter and reports
//            pending changes and rejected bounces. Optional input synchronizer
//            is enabled by defining SIGNAL_DEBOUNCER_SYNC_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module signal_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic signal,
    output logic clean,
    output logic busy,
    output logic glitch
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    generate
        if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > ((2 ** CNT_W) - 1))) begin : g_bad_stable_cycles
            $error("signal_debouncer: STABLE_CYCLES out of range 2..2^CNT_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    logic             w_sample;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_reject;
    logic             r_clean;
    logic             r_busy;
    logic             r_glitch;

`ifdef SIGNAL_DEBOUNCER_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], signal};
        end
    end

    assign w_sample = r_sync[1];
`else
    assign w_sample = signal;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= STABLE_LO;
            r_cnt    <= '0;
            r_clean  <= 1'b0;
            r_busy   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_clean  <= (w_state_next == STABLE_HI) || (w_state_next == PEND_LO);
            r_busy   <= (w_state_next == PEND_HI) || (w_state_next == PEND_LO);
            r_glitch <= w_reject;
        end
    end

    // The entry sample counts as the first, so qualification completes at C_LAST.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_reject     = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_sample) begin
                    w_state_next = PEND_HI;
                    w_cnt_next   = C_ONE;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            PEND_HI: begin
                if (w_sample) begin
                    if (r_cnt == C_LAST) begin
                        w_state_next = STABLE_HI;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt + C_ONE;
                    end
                end else begin
                    w_state_next = STABLE_LO;
                    w_cnt_next   = '0;
                    w_reject     = 1'b1;
                end
            end
            STABLE_HI: begin
                if (!w_sample) begin
                    w_state_next = PEND_LO;
                    w_cnt_next   = C_ONE;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            PEND_LO: begin
                if (!w_sample) begin
                    if (r_cnt == C_LAST) begin
                        w_state_next = STABLE_LO;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt + C_ONE;
                    end
                end else begin
                    w_state_next = STABLE_HI;
                    w_cnt_next   = '0;
                    w_reject     = 1'b1;
                end
            end
            default: begin
                w_state_next = STABLE_LO;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign clean  = r_clean;
    assign busy   = r_busy;
    assign glitch = r_glitch;

endmodule

`default_nettype wire

// File: tb/tb_signal_debouncer.sv
//==============================================================================
// Module   : tb_signal_debouncer
// Purpose  : Self-checking bench for signal_debouncer (directed + random).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_signal_debouncer;

    localparam int SC = 4;
`ifdef SIGNAL_DEBOUNCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic signal = 1'b0;
    logic clean;
    logic busy;
    logic glitch;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    signal_debouncer #(
        .STABLE_CYCLES (SC),
        .CNT_W         (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .signal (signal),
        .clean  (clean),
        .busy   (busy),
        .glitch (glitch)
    );

    always #5 clk = ~clk;

    // Reference: count consecutive samples that disagree with the accepted level.
    logic [2:0] m_d = 3'b000;
    logic       m_s;
    logic       m_clean = 1'b0;
    logic       m_glitch = 1'b0;
    int         m_run = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_d      = 3'b000;
            m_clean  = 1'b0;
            m_glitch = 1'b0;
            m_run    = 0;
        end else begin
            m_d      = {m_d[1:0], signal};
            m_s      = m_d[LAT];
            m_glitch = 1'b0;
            if (m_s != m_clean) begin
                m_run = m_run + 1;
                if (m_run == SC) begin
                    m_clean = m_s;
                    m_run   = 0;
                end
            end else begin
                if (m_run > 0) m_glitch = 1'b1;
                m_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_clean", clean, m_clean);
            check("model_busy", busy, (m_run != 0));
            check("model_glitch", glitch, m_glitch);
        end
    end

    // Advance n rising edges, returning at the following falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    int hold;

    initial begin
        // Reset held with signal high: outputs stay low throughout.
        reset  = 1'b0;
        signal = 1'b1;
        step(1);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_clean", clean, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_glitch", glitch, 1'b0);
            step(1);
        end

        // Rise qualification: busy after LAT+1 edges, clean after LAT+SC edges.
        signal = 1'b0;
        step(1);
        reset = 1'b1;
        step(4);
        signal = 1'b1;
        step(LAT);
        check("rise_busy_early", busy, 1'b0);
        step(1);
        check("rise_busy", busy, 1'b1);
        check("rise_clean_early", clean, 1'b0);
        step(SC - 2);
        check("rise_clean_pending", clean, 1'b0);
        step(1);
        check("rise_clean", clean, 1'b1);
        check("rise_busy_done", busy, 1'b0);
        step(6);

        // Low bounce of 3 samples while high: rejected with one glitch pulse.
        signal = 1'b0;
        step(3);
        signal = 1'b1;
        step(LAT);
        check("lo_bounce_glitch_early", glitch, 1'b0);
        step(1);
        check("lo_bounce_glitch", glitch, 1'b1);
        check("lo_bounce_clean", clean, 1'b1);
        step(1);
        check("lo_bounce_glitch_end", glitch, 1'b0);
        step(4);

        // Fall qualification.
        signal = 1'b0;
        step(LAT + SC - 1);
        check("fall_clean_pending", clean, 1'b1);
        step(1);
        check("fall_clean", clean, 1'b0);
        step(6);

        // High bounce of 2 samples while low.
        signal = 1'b1;
        step(2);
        signal = 1'b0;
        step(LAT);
        check("hi_bounce_busy1", busy, 1'b1);
        step(1);
        check("hi_bounce_glitch", glitch, 1'b1);
        check("hi_bounce_clean", clean, 1'b0);
        check("hi_bounce_busy_end", busy, 1'b0);
        step(1);
        check("hi_bounce_glitch_end", glitch, 1'b0);
        step(4);

        // Reset while a rise is pending.
        signal = 1'b1;
        step(LAT + 2);
        check("midpend_busy", busy, 1'b1);
        reset = 1'b0;
        step(1);
        check("midpend_rst_busy", busy, 1'b0);
        check("midpend_rst_clean", clean, 1'b0);
        check("midpend_rst_glitch", glitch, 1'b0);
        reset = 1'b1;
        signal = 1'b0;
        step(1);
        check("midpend_after_glitch", glitch, 1'b0);
        step(6);

        // Random bursts with occasional resets; the compare process checks each cycle.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                signal = ~signal;
                hold   = $urandom_range(1, SC + 3);
            end
            hold--;
            reset = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        reset = 1'b1;
        step(2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
